reg_shift_sequencer: RTL and testbench
======================================

// Module: reg_shift_sequencer
// PURPOSE
//  Multi-cycle sequencer for register-specified shifts (shift_operand[4]=1), the
//  operand form the single-cycle val2 path does not handle. Steps val_rm by the
//  amount in val_rs[7:0], SHIFT_STEP bits per cycle, with ARM >=32 semantics.
//  Sits beside the EXE val2 path and stalls the pipeline until the result is ready.
// PARAMETERS
//  SHIFT_STEP  4  bits shifted per SHIFT cycle; legal 1,2,4,8,16
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   synchronous reset, active-high
//  start          in   1   request; sampled in IDLE or DONE only
//  shift_type     in   2   00 LSL, 01 LSR, 10 ASR, 11 ROR
//  val_rm         in   32  operand to shift
//  val_rs         in   32  shift amount; only [7:0] used (n)
//  c_in           in   1   current C flag
//  flush          in   1   abort in-flight op (branch taken)
//  busy           out  1   state==SHIFT
//  stall          out  1   combinational: start | busy
//  done           out  1   one-cycle pulse, val2/shifter_carry valid
//  val2           out  32  shifted result; held until next accepted start
//  shifter_carry  out  1   shifter carry-out
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, val2=0, shifter_carry=0.
//  States: IDLE, SHIFT, DONE.
//  - IDLE/DONE + start: latch rm, n, type, c_in. Special case -> DONE; else -> SHIFT.
//  - SHIFT: each cycle shift working value by min(SHIFT_STEP, remaining).
//    remaining -= step. When remaining reaches 0 -> DONE.
//  - DONE: done=1 for exactly one cycle. Next state is IDLE unless start.
//  - start while in SHIFT: ignored. The requester holds start, so stall stays 1.
//  Latency (start at cycle 0, done cycle):
//  - special cases: cycle 1.
//  - 1<=n<=31: cycle ceil(n/SHIFT_STEP)+1.
//  - ROR: n in 33..255 with n[4:0]!=0 uses n[4:0].
//  Special cases (val2, carry):
//  - n==0: rm, c_in.
//  - LSL n==32: 0, rm[0]; LSL n>32: 0, 0.
//  - LSR n==32: 0, rm[31]; LSR n>32: 0, 0.
//  - ASR n>=32: {32{rm[31]}}, rm[31].
//  - ROR n!=0 and n[4:0]==0: rm, rm[31].
//  Carry for 1<=n<=31 is the last bit shifted out:
//  - LSL: rm[32-n]. LSR/ASR: rm[n-1]. ROR: result[31].
//  Arithmetic: ASR fills with rm[31]. ROR wraps bits, width stays 32. Step clamps at remaining.
//  flush: state->IDLE next cycle, no done, val2/carry keep previous values.
//  Priority: rst > flush > start. flush with start in IDLE: request dropped.
//  val2/shifter_carry change only on the DONE-entry edge.
// CONFIGURATION
//  REG_SHIFT_CARRY_EN defined: shifter_carry per rules above.
//  REG_SHIFT_CARRY_EN undefined:
//  - shifter_carry = latched c_in at every DONE; carry datapath removed.
//  - val2 and timing unchanged.
// TESTING (SHIFT_STEP=4 unless noted)
//  1 LSL rm=0x000000F1 n=4 -> done cycle 2, val2=0x00000F10, carry=0.
//  2 LSR rm=0xC0000000 n=31 -> busy cycles 1-8, done cycle 9, val2=0x00000001, carry=1.
//  3 ROR rm=0x12345678 n=8 -> done cycle 3, val2=0x78123456, carry=0.
//    ROR n=32 -> done cycle 1, val2=0x12345678, carry=0.
//  4 ASR rm=0x80000000 n=40 -> done cycle 1, val2=0xFFFFFFFF, carry=1.
//    rs=0x100 (n=0), c_in=1 -> val2=rm, carry=1.
//  5 LSL n=20, flush at cycle 3 -> IDLE cycle 4, no done, val2 unchanged.
//    Second start at cycle 2 ignored.
//  6 rst at cycle 2 mid-SHIFT -> all outputs 0 next cycle.
//    Rerun case 1 with REG_SHIFT_CARRY_EN off, c_in=1 -> carry=1.

Source files
------------

// File: rtl/reg_shift_sequencer_if.sv
// Request/result bundle between the EXE stage and the register-specified shift sequencer.
interface reg_shift_sequencer_if;
  logic        start;
  logic [1:0]  shift_type;
  logic [31:0] val_rm;
  logic [31:0] val_rs;
  logic        c_in;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] val2;
  logic        shifter_carry;

  modport master (
    output start, shift_type, val_rm, val_rs, c_in, flush,
    input  busy, stall, done, val2, shifter_carry
  );

  modport slave (
    input  start, shift_type, val_rm, val_rs, c_in, flush,
    output busy, stall, done, val2, shifter_carry
  );
endinterface

// File: rtl/reg_shift_sequencer.sv
// Multi-cycle ARM register-specified shifter, SHIFT_STEP bits per cycle.
// Define REG_SHIFT_CARRY_EN for a true shifter carry-out; otherwise carry-out is the latched C flag.
module reg_shift_sequencer #(
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  state_t      r_state;
  logic [31:0] r_work;
  logic [31:0] r_val2;
  logic [4:0]  r_rem;
  logic [1:0]  r_type;
  logic        r_carry;
  logic        r_busy;
  logic        r_done;
`ifndef REG_SHIFT_CARRY_EN
  logic        r_cin;
`endif

  logic [7:0]  w_n;
  logic        w_special;
  logic [31:0] w_sp_val;
  logic        w_sp_carry;
  logic [4:0]  w_k;
  logic [31:0] w_ror;
  logic [31:0] w_res;
`ifdef REG_SHIFT_CARRY_EN
  logic [32:0] w_ext;
  logic        w_c;
`endif
  logic        w_unused_rs;

  assign w_n         = bus.val_rs[7:0];
  assign w_unused_rs = ^bus.val_rs[31:8];

  // ROR with n[4:0]!=0 behaves as a plain 1..31 rotate, so only the other >=32 amounts are special
  assign w_special = (w_n == 8'd0) ||
                     ((bus.shift_type != 2'b11) && (w_n[7:5] != 3'd0)) ||
                     ((bus.shift_type == 2'b11) && (w_n[4:0] == 5'd0));

  always_comb begin
    w_sp_val   = bus.val_rm;
    w_sp_carry = bus.c_in;
    if (w_n != 8'd0) begin
      case (bus.shift_type)
        2'b00:   w_sp_val = '0;
        2'b01:   w_sp_val = '0;
        2'b10:   w_sp_val = {32{bus.val_rm[31]}};
        default: w_sp_val = bus.val_rm;
      endcase
`ifdef REG_SHIFT_CARRY_EN
      case (bus.shift_type)
        2'b00:   w_sp_carry = (w_n == 8'd32) ? bus.val_rm[0]  : 1'b0;
        2'b01:   w_sp_carry = (w_n == 8'd32) ? bus.val_rm[31] : 1'b0;
        default: w_sp_carry = bus.val_rm[31];
      endcase
`endif
    end
  end

  // One step of at most STEP bits; the carry is the last bit pushed out of the word
  always_comb begin
    w_k   = (r_rem < STEP) ? r_rem : STEP;
    w_ror = (r_work >> w_k) | (r_work << (6'd32 - {1'b0, w_k}));
`ifdef REG_SHIFT_CARRY_EN
    w_ext = '0;
    w_res = r_work;
    w_c   = 1'b0;
    case (r_type)
      2'b00: begin
        w_ext = {1'b0, r_work} << w_k;
        w_res = w_ext[31:0];
        w_c   = w_ext[32];
      end
      2'b01: begin
        w_ext = {r_work, 1'b0} >> w_k;
        w_res = w_ext[32:1];
        w_c   = w_ext[0];
      end
      2'b10: begin
        w_ext = 33'($signed({r_work, 1'b0}) >>> w_k);
        w_res = w_ext[32:1];
        w_c   = w_ext[0];
      end
      default: begin
        w_res = w_ror;
        w_c   = w_ror[31];
      end
    endcase
`else
    case (r_type)
      2'b00:   w_res = r_work << w_k;
      2'b01:   w_res = r_work >> w_k;
      2'b10:   w_res = 32'($signed(r_work) >>> w_k);
      default: w_res = w_ror;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_work  <= '0;
      r_val2  <= '0;
      r_rem   <= '0;
      r_type  <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifndef REG_SHIFT_CARRY_EN
      r_cin   <= 1'b0;
`endif
    end else if (bus.flush) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          if (bus.start) begin
            r_type <= bus.shift_type;
            r_work <= bus.val_rm;
            r_rem  <= w_n[4:0];
`ifndef REG_SHIFT_CARRY_EN
            r_cin  <= bus.c_in;
`endif
            if (w_special) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_val2  <= w_sp_val;
              r_carry <= w_sp_carry;
            end else begin
              r_state <= ST_SHIFT;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          r_work <= w_res;
          r_rem  <= r_rem - w_k;
          if (r_rem == w_k) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_val2  <= w_res;
`ifdef REG_SHIFT_CARRY_EN
            r_carry <= w_c;
`else
            r_carry <= r_cin;
`endif
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy          = r_busy;
  assign bus.stall         = bus.start | r_busy;
  assign bus.done          = r_done;
  assign bus.val2          = r_val2;
  assign bus.shifter_carry = r_carry;

endmodule

// File: tb/tb_reg_shift_sequencer.sv
// Randomized bench for reg_shift_sequencer against a whole-word ARM shift reference model.
module tb_reg_shift_sequencer;

  localparam int STEP = 4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [31:0] hold_val2;
  logic        hold_carry;

  reg_shift_sequencer_if bus();

  reg_shift_sequencer #(.SHIFT_STEP(STEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ARM shift by register computed on the whole word at once
  function automatic void model(input logic [1:0] t, input logic [31:0] rm, input logic [7:0] n,
                                input logic cin, output logic [31:0] v, output logic c,
                                output int lat);
    int unsigned a;
    logic [63:0] w;
    logic        special;
    a = n;
    if (t == 2'd3 && a >= 32 && (a % 32) != 0) a = a % 32;
    special = (a == 0) || (t != 2'd3 && a >= 32) || (t == 2'd3 && (a % 32) == 0);
    lat = special ? 1 : int'((a + STEP - 1) / STEP) + 1;
    v = rm;
    c = cin;
    if (a != 0) begin
      case (t)
        2'd0: begin
          w = {32'd0, rm} << a;
          v = (a >= 32) ? 32'd0 : w[31:0];
          c = (a > 32) ? 1'b0 : w[32];
        end
        2'd1: begin
          w = {rm, 32'd0} >> a;
          v = w[63:32];
          c = (a > 32) ? 1'b0 : w[31];
        end
        2'd2: begin
          w = {{32{rm[31]}}, rm};
          if (a >= 32) begin
            v = {32{rm[31]}};
            c = rm[31];
          end else begin
            v = 32'(w >> a);
            c = rm[a - 1];
          end
        end
        default: begin
          w = {rm, rm} >> (a % 32);
          v = w[31:0];
          c = v[31];
        end
      endcase
    end
`ifndef REG_SHIFT_CARRY_EN
    c = cin;
`endif
  endfunction

  // Caller is 1 time unit after a rising edge; returns in the done cycle (or after the budget)
  task automatic run_op(input string tag, input logic [1:0] t, input logic [31:0] rm,
                        input logic [31:0] rs, input logic cin);
    logic [31:0] ev;
    logic        ec;
    int          lat;
    int          cyc;
    model(t, rm, rs[7:0], cin, ev, ec, lat);
    bus.start      = 1'b1;
    bus.shift_type = t;
    bus.val_rm     = rm;
    bus.val_rs     = rs;
    bus.c_in       = cin;
    #1;
    check_eq({tag, ".stall_req"}, 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.val_rm = $urandom();
    bus.val_rs = $urandom();
    bus.c_in   = ~cin;
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      check_eq({tag, ".busy"}, 32'(bus.busy), 32'd1);
      check_eq({tag, ".stall"}, 32'(bus.stall), 32'd1);
      check_eq({tag, ".val2_hold"}, bus.val2, hold_val2);
      @(posedge clk); #1;
      cyc++;
    end
    check_eq({tag, ".latency"}, 32'(cyc), 32'(lat));
    check_eq({tag, ".val2"}, bus.val2, ev);
    check_eq({tag, ".carry"}, 32'(bus.shifter_carry), 32'(ec));
    check_eq({tag, ".busy_done"}, 32'(bus.busy), 32'd0);
    hold_val2  = ev;
    hold_carry = ec;
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    check_eq({tag, ".done_off"}, 32'(bus.done), 32'd0);
    check_eq({tag, ".busy_off"}, 32'(bus.busy), 32'd0);
    check_eq({tag, ".val2_held"}, bus.val2, hold_val2);
    check_eq({tag, ".carry_held"}, 32'(bus.shifter_carry), 32'(hold_carry));
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  n;
    logic [1:0]  t;
    n_vec = 0;
    n_err = 0;
    hold_val2  = '0;
    hold_carry = 1'b0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.shift_type = '0;
    bus.val_rm     = '0;
    bus.val_rs     = '0;
    bus.c_in       = 1'b0;
    bus.flush      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("reset.busy", 32'(bus.busy), 32'd0);
    check_eq("reset.done", 32'(bus.done), 32'd0);
    check_eq("reset.val2", bus.val2, 32'd0);
    check_eq("reset.carry", 32'(bus.shifter_carry), 32'd0);
    check_eq("reset.stall", 32'(bus.stall), 32'd0);

    run_op("lsl4", 2'd0, 32'h0000_00F1, 32'd4, 1'b1);
    check_eq("lsl4.const", bus.val2, 32'h0000_0F10);
    idle_check("lsl4");
    run_op("lsr31", 2'd1, 32'hC000_0000, 32'd31, 1'b0);
    check_eq("lsr31.const", bus.val2, 32'h0000_0001);
    idle_check("lsr31");
    run_op("ror8", 2'd3, 32'h1234_5678, 32'd8, 1'b1);
    check_eq("ror8.const", bus.val2, 32'h7812_3456);
    run_op("ror32", 2'd3, 32'h1234_5678, 32'd32, 1'b1);
    run_op("asr40", 2'd2, 32'h8000_0000, 32'd40, 1'b0);
    check_eq("asr40.const", bus.val2, 32'hFFFF_FFFF);
    run_op("rs100", 2'd1, 32'hDEAD_BEEF, 32'h0000_0100, 1'b1);
    run_op("lsl32", 2'd0, 32'h0000_0001, 32'd32, 1'b0);
    run_op("lsr33", 2'd1, 32'hFFFF_FFFF, 32'd33, 1'b0);
    run_op("ror37", 2'd3, 32'h8765_4321, 32'd37, 1'b0);
    run_op("asr1", 2'd2, 32'h8000_0003, 32'd1, 1'b0);
    idle_check("asr1");

    // flush mid-shift, with a second start ignored while shifting
    bus.start = 1'b1; bus.shift_type = 2'd0; bus.val_rm = 32'h0000_00F1;
    bus.val_rs = 32'd20; bus.c_in = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_eq("flush.busy1", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.shift_type = 2'd1; bus.val_rs = 32'd0;
    check_eq("flush.busy2", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b1;
    check_eq("flush.busy3", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check_eq("flush.idle_busy", 32'(bus.busy), 32'd0);
    check_eq("flush.idle_done", 32'(bus.done), 32'd0);
    repeat (6) idle_check("flush.after");

    // flush together with start in IDLE drops the request
    bus.start = 1'b1; bus.flush = 1'b1; bus.val_rs = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    check_eq("flushstart.busy", 32'(bus.busy), 32'd0);
    check_eq("flushstart.done", 32'(bus.done), 32'd0);
    idle_check("flushstart");

    // synchronous reset mid-shift
    bus.start = 1'b1; bus.shift_type = 2'd0; bus.val_rm = 32'h0000_00F1;
    bus.val_rs = 32'd20; bus.c_in = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rstmid.busy", 32'(bus.busy), 32'd0);
    check_eq("rstmid.done", 32'(bus.done), 32'd0);
    check_eq("rstmid.val2", bus.val2, 32'd0);
    check_eq("rstmid.carry", 32'(bus.shifter_carry), 32'd0);
    hold_val2  = '0;
    hold_carry = 1'b0;
    run_op("lsl4b", 2'd0, 32'h0000_00F1, 32'd4, 1'b1);

    for (int i = 0; i < 200; i++) begin
      r = $urandom();
      t = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       n = 8'd0;
        1:       n = 8'd32;
        2:       n = 8'($urandom_range(1, 31));
        3:       n = 8'($urandom_range(32, 255));
        4:       n = 8'($urandom_range(1, 7) * 32);
        default: n = 8'($urandom());
      endcase
      run_op("rand", t, $urandom(), {r[31:8], n}, 1'($urandom()));
      if ($urandom_range(0, 1) == 0) idle_check("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
